// File: rtl/spi_shift_engine.sv
// SPI mode-0 master shift engine: pops bytes from the TX FIFO, shifts them out MSB first,
// and pushes each received byte into the RX FIFO. All outputs are registered.
module spi_shift_engine #(
    parameter int DATAWIDTH = 8,
    parameter int CLKDIV    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DATAWIDTH-1:0] tx_dout,
    input  logic                 tx_empty,
    output logic                 tx_re_en,
    output logic [DATAWIDTH-1:0] rx_din,
    output logic                 rx_wr_en,
    input  logic                 rx_full,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 ss_n,
    output logic                 busy,
    output logic                 overrun
);

    localparam int HW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BW = (DATAWIDTH > 2) ? $clog2(DATAWIDTH) : 1;

    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, DONE, TRAIL} state_t;

    state_t               state, state_nxt;
    logic [HW-1:0]        hcnt, hcnt_nxt;
    logic [BW-1:0]        bcnt, bcnt_nxt;
    logic [DATAWIDTH-1:0] shreg, shreg_nxt;
    logic [DATAWIDTH-1:0] rxsh, rxsh_nxt;
    logic [DATAWIDTH-1:0] rx_din_nxt;
    logic                 sclk_nxt, mosi_nxt, ss_n_nxt;
    logic                 tx_re_en_nxt, rx_wr_en_nxt, overrun_nxt;
    logic                 load, half_done;

    assign half_done = (hcnt == HW'(CLKDIV - 1));

    always_comb begin
        state_nxt    = state;
        hcnt_nxt     = hcnt;
        bcnt_nxt     = bcnt;
        shreg_nxt    = shreg;
        rxsh_nxt     = rxsh;
        rx_din_nxt   = rx_din;
        sclk_nxt     = sclk;
        mosi_nxt     = mosi;
        ss_n_nxt     = ss_n;
        tx_re_en_nxt = 1'b0;
        rx_wr_en_nxt = 1'b0;
        overrun_nxt  = overrun;
        load         = 1'b0;

        case (state)
            IDLE: begin
                if (en && !tx_empty) begin
                    load      = 1'b1;
                    state_nxt = LEAD;
                end
            end
            LEAD, LOW: begin
                if (half_done) begin
                    hcnt_nxt  = '0;
                    sclk_nxt  = 1'b1;
                    rxsh_nxt  = {rxsh[DATAWIDTH-2:0], miso};
                    state_nxt = HIGH;
                end else begin
                    hcnt_nxt = hcnt + 1'b1;
                end
            end
            HIGH: begin
                if (half_done) begin
                    hcnt_nxt = '0;
                    sclk_nxt = 1'b0;
                    if (bcnt != BW'(DATAWIDTH - 1)) begin
                        mosi_nxt  = shreg[DATAWIDTH-2];
                        shreg_nxt = {shreg[DATAWIDTH-2:0], 1'b0};
                        bcnt_nxt  = bcnt + 1'b1;
                        state_nxt = LOW;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    hcnt_nxt = hcnt + 1'b1;
                end
            end
            DONE: begin
                // A full RX FIFO drops the byte rather than stalling the bus.
                if (!rx_full) begin
                    rx_wr_en_nxt = 1'b1;
                    rx_din_nxt   = rxsh;
                end else begin
                    overrun_nxt = 1'b1;
                end
                if (en && !tx_empty) begin
                    load      = 1'b1;
                    state_nxt = LOW;
                end else begin
                    state_nxt = TRAIL;
                end
            end
            TRAIL: begin
                if (half_done) begin
                    hcnt_nxt  = '0;
                    ss_n_nxt  = 1'b1;
                    mosi_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    hcnt_nxt = hcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            shreg_nxt    = tx_dout;
            mosi_nxt     = tx_dout[DATAWIDTH-1];
            ss_n_nxt     = 1'b0;
            bcnt_nxt     = '0;
            hcnt_nxt     = '0;
            tx_re_en_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state    <= IDLE;
            hcnt     <= '0;
            bcnt     <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= 1'b1;
            busy     <= 1'b0;
            tx_re_en <= 1'b0;
            rx_wr_en <= 1'b0;
            rx_din   <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hcnt     <= hcnt_nxt;
            bcnt     <= bcnt_nxt;
            sclk     <= sclk_nxt;
            mosi     <= mosi_nxt;
            ss_n     <= ss_n_nxt;
            busy     <= (state_nxt != IDLE);
            tx_re_en <= tx_re_en_nxt;
            rx_wr_en <= rx_wr_en_nxt;
            rx_din   <= rx_din_nxt;
            overrun  <= overrun_nxt;
        end
    end

    // Shift registers carry data only; a frame always reloads them before use.
    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
        rxsh  <= rxsh_nxt;
    end

endmodule
